// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage:
// FSM encoding, datapath widths and the queue entry layout.
package fetch_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 64;
    localparam logic [PC_W-1:0] PC_INC = 64'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request bus and downstream instruction handshake.
// The fetch unit is the master; memory and the decode stage form the slave side.
interface fetch_if;
    import fetch_pkg::*;

    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic              imem_ack;
    logic [INST_W-1:0] imem_rdata;

    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic              inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ack, imem_rdata, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ack, imem_rdata, inst_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {instruction, pc} pairs.
// Flush wins over push and pop; QDEPTH must be a power of two.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2,
    localparam int PTR_W = $clog2(QDEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  fetch_entry_t     push_entry,
    output fetch_entry_t     head,
    output logic             head_valid,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem_q [QDEPTH];
    fetch_entry_t     mem_d [QDEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads over req/ack,
// queues returned words and hands them downstream; redirects flush and refetch.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic [PC_W-1:0] startpc,
    fetch_if.master         bus,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] currentpc
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QDEPTH);

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PC_W-1:0]  addr_q, addr_d;
    logic             req_q, req_d;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_after;
    logic             head_valid;
    logic             do_push;
    logic             do_pop;
    fetch_entry_t     head;
    fetch_entry_t     push_entry;

    assign do_pop      = head_valid && bus.inst_ready;
    assign push_entry  = '{inst: bus.imem_rdata, pc: addr_q};
    assign count_after = count + CNT_W'(1) - CNT_W'(do_pop);

    // Occupancy after an ack (enqueue plus any same-cycle dequeue) decides
    // whether the next request can go out back-to-back.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        do_push = 1'b0;
        if (redirect_valid) begin
            pc_d = align_pc(redirect_pc);
            if (state_q == IDLE) begin
                state_d = IDLE;
            end else begin
                state_d = bus.imem_ack ? IDLE : DROP;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (count < DEPTH_C) begin
                        state_d = WAIT;
                        addr_d  = pc_q;
                    end
                end
                WAIT: begin
                    if (bus.imem_ack) begin
                        do_push = 1'b1;
                        pc_d    = pc_q + PC_INC;
                        addr_d  = pc_q + PC_INC;
                        state_d = (count_after < DEPTH_C) ? WAIT : IDLE;
                    end
                end
                DROP: begin
                    if (bus.imem_ack) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        req_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= startpc;
            addr_q  <= startpc;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    fetch_queue #(
        .QDEPTH(QDEPTH)
    ) u_queue (
        .clk       (CLK),
        .rst       (reset),
        .flush     (redirect_valid),
        .push      (do_push),
        .pop       (do_pop),
        .push_entry(push_entry),
        .head      (head),
        .head_valid(head_valid),
        .count     (count)
    );

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_valid = head_valid;
    assign bus.inst       = head.inst;
    assign bus.inst_pc    = head.pc;
    assign currentpc      = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model feeds the
// DUT and a scoreboard of expected {pc, inst} deliveries checks the output side.
module tb_fetch_unit;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    logic        CLK;
    logic        reset;
    logic [63:0] startpc;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [63:0] currentpc;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   mem_lat;
    int   mem_cnt;
    bit   mon_en;
    exp_t exp_q[$];

    fetch_if bus();

    fetch_unit #(
        .QDEPTH(2)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .startpc       (startpc),
        .bus           (bus),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .currentpc     (currentpc)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    // Memory acks a request once it has been held for mem_lat cycles.
    always_comb begin
        bus.imem_ack   = bus.imem_req && (mem_cnt >= mem_lat - 1);
        bus.imem_rdata = mem_word(bus.imem_addr);
    end

    always @(posedge CLK or posedge reset) begin
        if (reset) begin
            mem_cnt <= 0;
        end else if (!bus.imem_req || bus.imem_ack) begin
            mem_cnt <= 0;
        end else begin
            mem_cnt <= mem_cnt + 1;
        end
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (mon_en && bus.inst_valid && bus.inst_ready) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("[TB] FAIL unexpected_delivery: observed inst_pc %h, expected no delivery",
                       bus.inst_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check_output("deliver_pc", bus.inst_pc, e.pc);
                check_output("deliver_inst", 64'(bus.inst), 64'(e.inst));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Leaves the bench at the start of cycle 0 after reset release.
    task automatic apply_stimulus(input logic [63:0] spc, input int lat, input logic rdy);
        mon_en         = 1'b0;
        reset          = 1'b1;
        startpc        = spc;
        mem_lat        = lat;
        bus.inst_ready = rdy;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        exp_q.delete();
        tick(2);
        reset = 1'b0;
    endtask

    task automatic push_exp(input logic [63:0] pc);
        exp_q.push_back('{pc: pc, inst: mem_word(pc)});
    endtask

    task automatic end_window(input string tag);
        mon_en = 1'b0;
        check_output(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        startpc        = 64'h30;
        bus.inst_ready = 1'b1;
        mem_lat        = 1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mon_en         = 1'b0;
        tick(3);
        check_output("rst_req", 64'(bus.imem_req), 64'd0);
        check_output("rst_addr", bus.imem_addr, 64'h30);
        check_output("rst_valid", 64'(bus.inst_valid), 64'd0);
        check_output("rst_inst", 64'(bus.inst), 64'd0);
        check_output("rst_inst_pc", bus.inst_pc, 64'd0);
        check_output("rst_currentpc", currentpc, 64'h30);

        $display("[TB] zero-wait streaming from 0x30");
        apply_stimulus(64'h30, 1, 1'b1);
        push_exp(64'h30); push_exp(64'h34); push_exp(64'h38); push_exp(64'h3C);
        mon_en = 1'b1;
        check_output("s_c0_req", 64'(bus.imem_req), 64'd0);
        tick();
        check_output("s_c1_req", 64'(bus.imem_req), 64'd1);
        check_output("s_c1_addr", bus.imem_addr, 64'h30);
        check_output("s_c1_valid", 64'(bus.inst_valid), 64'd0);
        tick();
        check_output("s_c2_addr", bus.imem_addr, 64'h34);
        check_output("s_c2_valid", 64'(bus.inst_valid), 64'd1);
        check_output("s_c2_inst_pc", bus.inst_pc, 64'h30);
        tick();
        check_output("s_c3_addr", bus.imem_addr, 64'h38);
        tick(3);
        end_window("s_drained");

        $display("[TB] backpressure fills queue");
        apply_stimulus(64'h0, 1, 1'b0);
        tick();
        check_output("bp_c1_req", 64'(bus.imem_req), 64'd1);
        check_output("bp_c1_addr", bus.imem_addr, 64'h0);
        tick();
        check_output("bp_c2_req", 64'(bus.imem_req), 64'd1);
        check_output("bp_c2_addr", bus.imem_addr, 64'h4);
        tick();
        check_output("bp_c3_req", 64'(bus.imem_req), 64'd0);
        check_output("bp_c3_valid", 64'(bus.inst_valid), 64'd1);
        check_output("bp_c3_inst_pc", bus.inst_pc, 64'h0);
        tick(3);
        check_output("bp_c6_req", 64'(bus.imem_req), 64'd0);
        check_output("bp_c6_inst_pc", bus.inst_pc, 64'h0);
        check_output("bp_c6_currentpc", currentpc, 64'h8);
        push_exp(64'h0); push_exp(64'h4); push_exp(64'h8);
        mon_en         = 1'b1;
        bus.inst_ready = 1'b1;
        tick();
        check_output("bp_c7_req", 64'(bus.imem_req), 64'd0);
        check_output("bp_c7_inst_pc", bus.inst_pc, 64'h4);
        tick();
        check_output("bp_c8_req", 64'(bus.imem_req), 64'd1);
        check_output("bp_c8_addr", bus.imem_addr, 64'h8);
        tick(2);
        end_window("bp_drained");

        $display("[TB] three-cycle memory latency");
        apply_stimulus(64'h100, 3, 1'b1);
        push_exp(64'h100); push_exp(64'h104);
        mon_en = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_output($sformatf("lat_c%0d_addr", c), bus.imem_addr, 64'h100);
            check_output($sformatf("lat_c%0d_req", c), 64'(bus.imem_req), 64'd1);
        end
        tick();
        check_output("lat_c4_addr", bus.imem_addr, 64'h104);
        check_output("lat_c4_valid", 64'(bus.inst_valid), 64'd1);
        check_output("lat_c4_inst_pc", bus.inst_pc, 64'h100);
        tick();
        check_output("lat_c5_valid", 64'(bus.inst_valid), 64'd0);
        tick();
        check_output("lat_c6_valid", 64'(bus.inst_valid), 64'd0);
        tick();
        check_output("lat_c7_valid", 64'(bus.inst_valid), 64'd1);
        check_output("lat_c7_inst_pc", bus.inst_pc, 64'h104);
        tick();
        end_window("lat_drained");

        $display("[TB] redirect while request outstanding");
        apply_stimulus(64'h10, 3, 1'b1);
        push_exp(64'h3C);
        mon_en = 1'b1;
        tick();
        check_output("dr_c1_addr", bus.imem_addr, 64'h10);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3D;
        tick();
        redirect_valid = 1'b0;
        check_output("dr_c3_req", 64'(bus.imem_req), 64'd1);
        check_output("dr_c3_addr", bus.imem_addr, 64'h10);
        check_output("dr_c3_currentpc", currentpc, 64'h3C);
        check_output("dr_c3_valid", 64'(bus.inst_valid), 64'd0);
        tick();
        check_output("dr_c4_req", 64'(bus.imem_req), 64'd0);
        tick();
        check_output("dr_c5_req", 64'(bus.imem_req), 64'd1);
        check_output("dr_c5_addr", bus.imem_addr, 64'h3C);
        tick(3);
        check_output("dr_c8_valid", 64'(bus.inst_valid), 64'd1);
        check_output("dr_c8_inst_pc", bus.inst_pc, 64'h3C);
        tick();
        end_window("dr_drained");

        $display("[TB] redirect coincident with ack and dequeue");
        apply_stimulus(64'h200, 1, 1'b1);
        push_exp(64'h200); push_exp(64'h400);
        mon_en = 1'b1;
        tick();
        check_output("rc_c1_addr", bus.imem_addr, 64'h200);
        tick();
        check_output("rc_c2_ack", 64'(bus.imem_ack), 64'd1);
        check_output("rc_c2_inst_pc", bus.inst_pc, 64'h200);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h400;
        tick();
        redirect_valid = 1'b0;
        check_output("rc_c3_valid", 64'(bus.inst_valid), 64'd0);
        check_output("rc_c3_currentpc", currentpc, 64'h400);
        check_output("rc_c3_req", 64'(bus.imem_req), 64'd0);
        tick();
        check_output("rc_c4_req", 64'(bus.imem_req), 64'd1);
        check_output("rc_c4_addr", bus.imem_addr, 64'h400);
        tick();
        check_output("rc_c5_inst_pc", bus.inst_pc, 64'h400);
        tick();
        end_window("rc_drained");

        $display("[TB] PC wrap and asynchronous reset mid-request");
        apply_stimulus(64'hFFFF_FFFF_FFFF_FFFC, 1, 1'b1);
        tick();
        check_output("wr_c1_addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check_output("wr_c2_addr", bus.imem_addr, 64'h0);
        check_output("wr_c2_currentpc", currentpc, 64'h0);
        check_output("wr_c2_inst_pc", bus.inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        check_output("wr_c3_req", 64'(bus.imem_req), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_output("async_rst_req", 64'(bus.imem_req), 64'd0);
        check_output("async_rst_currentpc", currentpc, 64'hFFFF_FFFF_FFFF_FFFC);
        check_output("async_rst_valid", 64'(bus.inst_valid), 64'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the single-cycle datapath's decode logic. It owns the fetch PC, issues word reads to instruction memory over a req/ack handshake, buffers returned instructions in a small queue, and hands them downstream with a valid/ready handshake. Branch redirects from execute flush the queue and restart fetch at the new target; `currentpc` exposes the fetch PC to the bench.

## Interface
- `QDEPTH`, 2: instruction queue entries (power of two, ≥2).
- `CLK`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `startpc`  in  64  PC loaded while `reset` is high.
- `imem_req`  out  1  instruction read request.
- `imem_addr`  out  64  read address, word aligned.
- `imem_ack`  in  1  request accepted; `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  one-cycle pulse: flush and refetch.
- `redirect_pc`  in  64  redirect target; bits [1:0] ignored, treated as 0.
- `inst_valid`  out  1  queue head valid.
- `inst`  out  32  queue head instruction.
- `inst_pc`  out  64  address of `inst`.
- `inst_ready`  in  1  consumer accepts head.
- `currentpc`  out  64  address of next request to be issued (fetch PC).

## Operation
- FSM states: IDLE (no request), WAIT (request outstanding), DROP (request outstanding, data to be discarded).
- Space check: new request allowed when `count + (state==WAIT) < QDEPTH`, counting the outstanding fetch.
- IDLE: if space → WAIT, `imem_addr`=fetch PC. Otherwise stay.
- WAIT: `imem_req`=1, `imem_addr` stable until `imem_ack`. On ack: enqueue {rdata, addr}; fetch PC += 4; if space remains after the enqueue → stay WAIT with new address, else → IDLE.
- DROP: `imem_req` held, address unchanged; on ack discard data → IDLE.
- Redirect (highest priority): queue emptied, fetch PC = {redirect_pc[63:2],2'b00}. If WAIT without ack this cycle → DROP. If ack same cycle → data discarded, → IDLE. In DROP, a further redirect only updates fetch PC.
- Dequeue when `inst_valid && inst_ready`; enqueue and dequeue in the same cycle leave `count` unchanged. Redirect overrides both.
- PC arithmetic modulo 2^64; 0xFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- `inst`/`inst_pc` stable while `inst_valid && !inst_ready`.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`startpc`, `inst_valid`=0, `inst`=0, `inst_pc`=0, `currentpc`=`startpc`, state IDLE, count 0.
- Cycle 0 after reset release: IDLE. Cycle 1: `imem_req`=1. Zero-wait ack in cycle 1 → `inst_valid`=1 in cycle 2.
- Sustained throughput with zero-wait memory and `inst_ready`=1: one instruction per cycle.
- Redirect in cycle N: `inst_valid`=0 in N+1; new-target request no earlier than N+2 (later if DROP must drain).
- Reset mid-request: `imem_req` drops immediately (async); the memory must discard it.

## Structure
- Shared package `fetch_pkg`: FSM state encoding (IDLE/WAIT/DROP), `INST_W`=32, `PC_W`=64, `PC_INC`=4.
- One sub-module: `fetch_queue`, a QDEPTH-entry synchronous FIFO with flush, push, pop, count, head outputs.
- Control FSM and PC register in the top level.

## Test plan
- Reset with `startpc`=0x30, zero-wait memory, `inst_ready`=1 → requests 0x30, 0x34, 0x38 on consecutive cycles starting cycle 1; `inst_pc`=0x30 in cycle 2.
- `inst_ready`=0, zero-wait memory → exactly QDEPTH (2) fetches issued, then `imem_req`=0; `inst_pc` held at 0x0; release ready → fetch resumes at 0x8.
- 3-cycle ack latency → `imem_addr` constant across all 3 cycles; one instruction per 3 cycles delivered.
- Redirect to 0x3D while a 3-cycle request to 0x10 is outstanding → DROP; 0x10 data never appears; next request 0x3C; first delivered `inst_pc`=0x3C.
- Redirect coincident with ack and dequeue → queue empty next cycle, acked data discarded, `currentpc`=redirect target.
- `startpc`=0xFFFF_FFFF_FFFF_FFFC → second request at 0x0; reset asserted mid-WAIT → `imem_req`=0 without waiting for a clock edge.
